// File: rtl/remap_pixel_fetch.sv
// Remapped-coordinate pixel fetch: bounds check, linear frame-buffer read,
// latency realignment and AXI-Stream output with line/frame markers.
module remap_pixel_fetch #(
  parameter int IMG_W      = 1080,
  parameter int IMG_H      = 960,
  parameter int ADDR_W     = 20,
  parameter int PIX_W      = 12,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int FILL       = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [11:0]       x_in,
  input  logic [11:0]       y_in,
  input  logic              addr_vld,
  output logic              mem_ready,
  output logic [ADDR_W-1:0] bram_addr,
  output logic              bram_en,
  input  logic [PIX_W-1:0]  bram_dout,
  output logic [PIX_W-1:0]  m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast,
  output logic              m_tuser,
  output logic              overflow_err
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [PIX_W-1:0] FILL_PIX = PIX_W'(FILL);

  logic [CNT_W-1:0]  credit;
  logic              accept;
  logic              handshake;
  logic              in_range;
  logic [ADDR_W-1:0] lin_addr;
  logic              a_vld;
  logic              a_oob;
  logic [RD_LAT-1:0] sr_vld;
  logic [RD_LAT-1:0] sr_oob;
  logic              fifo_wr;
  logic [PIX_W-1:0]  fifo_wdata;
  logic [PIX_W-1:0]  fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  fifo_cnt;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;

  // Credits cover both in-flight reads and FIFO entries, so the FIFO cannot overflow.
  assign mem_ready = !reset && (credit < CNT_W'(FIFO_DEPTH));
  assign accept    = addr_vld && mem_ready;
  assign in_range  = (32'(x_in) < 32'(IMG_W)) && (32'(y_in) < 32'(IMG_H));
  // Modular arithmetic: computing at ADDR_W gives the same low bits as full width.
  assign lin_addr  = ADDR_W'(y_in) * ADDR_W'(IMG_W) + ADDR_W'(x_in);

  always_ff @(posedge clk) begin
    if (reset) begin
      bram_en      <= 1'b0;
      bram_addr    <= '0;
      a_vld        <= 1'b0;
      a_oob        <= 1'b0;
      overflow_err <= 1'b0;
      credit       <= '0;
    end else begin
      bram_en <= accept && in_range;
      if (accept && in_range)
        bram_addr <= lin_addr;
      a_vld <= accept;
      a_oob <= !in_range;
      if (addr_vld && !mem_ready)
        overflow_err <= 1'b1;
      case ({accept, handshake})
        2'b10:   credit <= credit + CNT_W'(1);
        2'b01:   credit <= credit - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Request flags ride alongside the BRAM read so they exit with bram_dout.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_vld <= '0;
      sr_oob <= '0;
    end else begin
      sr_vld[0] <= a_vld;
      sr_oob[0] <= a_oob;
      for (int i = 1; i < RD_LAT; i++) begin
        sr_vld[i] <= sr_vld[i-1];
        sr_oob[i] <= sr_oob[i-1];
      end
    end
  end

  assign fifo_wr    = sr_vld[RD_LAT-1];
  assign fifo_wdata = sr_oob[RD_LAT-1] ? FILL_PIX : bram_dout;

  always_ff @(posedge clk) begin
    if (fifo_wr)
      fifo_mem[wr_ptr] <= fifo_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (fifo_wr)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (handshake)
        rd_ptr <= rd_ptr + PTR_W'(1);
      case ({fifo_wr, handshake})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: ;
      endcase
    end
  end

  assign m_tvalid  = (fifo_cnt != '0);
  assign handshake = m_tvalid && m_tready;
  assign m_tdata   = m_tvalid ? fifo_mem[rd_ptr] : '0;
  assign m_tlast   = m_tvalid && (col == COL_W'(IMG_W - 1));
  assign m_tuser   = m_tvalid && (col == '0) && (row == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (handshake) begin
      if (col == COL_W'(IMG_W - 1)) begin
        col <= '0;
        row <= (row == ROW_W'(IMG_H - 1)) ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_remap_pixel_fetch.sv
// Directed bench for remap_pixel_fetch: full-size instance with scoreboard,
// plus a 4x3 instance for line/frame marker wrap.
module tb_remap_pixel_fetch;
  localparam int IMG_W  = 1080;
  localparam int IMG_H  = 960;
  localparam int DEPTH  = 8;
  localparam int RD_LAT = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [11:0] x_in = '0;
  logic [11:0] y_in = '0;
  logic        addr_vld = 1'b0;
  logic        m_tready = 1'b0;
  logic        mem_ready, bram_en, m_tvalid, m_tlast, m_tuser, overflow_err;
  logic [19:0] bram_addr;
  logic [11:0] bram_dout, m_tdata;

  logic [11:0] s_x = '0;
  logic [11:0] s_y = '0;
  logic        s_addr_vld = 1'b0;
  logic        s_tready = 1'b1;
  logic        s_mem_ready, s_bram_en, s_tvalid, s_tlast, s_tuser, s_overflow;
  logic [3:0]  s_bram_addr;
  logic [11:0] s_bram_dout, s_tdata;

  remap_pixel_fetch #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(20), .PIX_W(12),
                      .RD_LAT(RD_LAT), .FIFO_DEPTH(DEPTH), .FILL(0)) dut (
    .clk(clk), .reset(reset), .x_in(x_in), .y_in(y_in), .addr_vld(addr_vld),
    .mem_ready(mem_ready), .bram_addr(bram_addr), .bram_en(bram_en),
    .bram_dout(bram_dout), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
    .m_tready(m_tready), .m_tlast(m_tlast), .m_tuser(m_tuser),
    .overflow_err(overflow_err));

  remap_pixel_fetch #(.IMG_W(4), .IMG_H(3), .ADDR_W(4), .PIX_W(12),
                      .RD_LAT(RD_LAT), .FIFO_DEPTH(DEPTH), .FILL(0)) dut_s (
    .clk(clk), .reset(reset), .x_in(s_x), .y_in(s_y), .addr_vld(s_addr_vld),
    .mem_ready(s_mem_ready), .bram_addr(s_bram_addr), .bram_en(s_bram_en),
    .bram_dout(s_bram_dout), .m_tdata(s_tdata), .m_tvalid(s_tvalid),
    .m_tready(s_tready), .m_tlast(s_tlast), .m_tuser(s_tuser),
    .overflow_err(s_overflow));

  // BRAM models: data = address LSBs, RD_LAT cycles after the enable cycle.
  logic [11:0] bpipe   [RD_LAT];
  logic [11:0] s_bpipe [RD_LAT];
  always @(posedge clk) begin
    bpipe[0]   <= bram_en ? bram_addr[11:0] : 12'hBAD;
    s_bpipe[0] <= s_bram_en ? {8'h00, s_bram_addr} : 12'hBAD;
    for (int i = 1; i < RD_LAT; i++) begin
      bpipe[i]   <= bpipe[i-1];
      s_bpipe[i] <= s_bpipe[i-1];
    end
  end
  assign bram_dout   = bpipe[RD_LAT-1];
  assign s_bram_dout = s_bpipe[RD_LAT-1];

  int n_cmp = 0;
  int n_bad = 0;
  int m_credit = 0;
  int mcol = 0;
  int mrow = 0;
  int n_out = 0;
  logic [11:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] exp_pix(input int x, input int y);
    int a;
    a = 0;
    if (x < IMG_W && y < IMG_H) a = y * IMG_W + x;
    return a[11:0];
  endfunction

  // One clock of the full-size instance: checks mem_ready against the credit
  // model, scores any output handshake, then advances past the edge.
  task automatic tick();
    logic exp_mr, acc, hs;
    logic [11:0] e;
    #1;
    exp_mr = !reset && (m_credit < DEPTH);
    chk("mem_ready", {31'b0, mem_ready}, {31'b0, exp_mr});
    acc = addr_vld && exp_mr;
    hs  = !reset && m_tvalid && m_tready;
    if (hs) begin
      if (exp_q.size() == 0) begin
        chk("extra_pixel", {31'b0, m_tvalid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("m_tdata", {20'b0, m_tdata}, {20'b0, e});
        chk("m_tuser", {31'b0, m_tuser}, {31'b0, (mcol == 0 && mrow == 0)});
        chk("m_tlast", {31'b0, m_tlast}, {31'b0, (mcol == IMG_W - 1)});
        if (mcol == IMG_W - 1) begin
          mcol = 0;
          mrow = (mrow == IMG_H - 1) ? 0 : mrow + 1;
        end else begin
          mcol++;
        end
        n_out++;
      end
    end
    if (acc) exp_q.push_back(exp_pix(int'(x_in), int'(y_in)));
    m_credit = m_credit + (acc ? 1 : 0) - (hs ? 1 : 0);
    @(posedge clk);
    #1;
    if (reset) begin
      exp_q.delete();
      m_credit = 0;
      mcol = 0;
      mrow = 0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1);
  end

  initial begin
    int n0;
    int sn_out;
    bit started;
    logic [11:0] head;

    // Reset values
    reset = 1'b1;
    repeat (3) tick();
    chk("rst_bram_en", {31'b0, bram_en}, 32'd0);
    chk("rst_bram_addr", {12'b0, bram_addr}, 32'd0);
    chk("rst_m_tvalid", {31'b0, m_tvalid}, 32'd0);
    chk("rst_m_tdata", {20'b0, m_tdata}, 32'd0);
    chk("rst_m_tlast", {31'b0, m_tlast}, 32'd0);
    chk("rst_m_tuser", {31'b0, m_tuser}, 32'd0);
    chk("rst_overflow", {31'b0, overflow_err}, 32'd0);
    reset = 1'b0;
    #1;
    chk("ready_after_rst", {31'b0, mem_ready}, 32'd1);

    // Single in-range request, latency and first-pixel marker
    x_in = 12'd5; y_in = 12'd2; addr_vld = 1'b1;
    tick();
    addr_vld = 1'b0;
    chk("t1_bram_en", {31'b0, bram_en}, 32'd1);
    chk("t1_bram_addr", {12'b0, bram_addr}, 32'd2165);
    m_tready = 1'b1;
    tick();
    chk("t1_bram_en_off", {31'b0, bram_en}, 32'd0);
    tick();
    chk("t1_valid_c3", {31'b0, m_tvalid}, 32'd0);
    tick();
    chk("t1_valid_c4", {31'b0, m_tvalid}, 32'd1);
    chk("t1_tdata", {20'b0, m_tdata}, 32'd2165);
    chk("t1_tuser", {31'b0, m_tuser}, 32'd1);
    chk("t1_tlast", {31'b0, m_tlast}, 32'd0);
    tick();
    chk("t1_valid_after", {31'b0, m_tvalid}, 32'd0);

    // Out-of-range requests emit FILL, no BRAM read
    n0 = n_out;
    x_in = 12'd1080; y_in = 12'd0; addr_vld = 1'b1;
    tick();
    chk("t2_en_a", {31'b0, bram_en}, 32'd0);
    chk("t2_addr_hold", {12'b0, bram_addr}, 32'd2165);
    x_in = 12'd0; y_in = 12'd4095;
    tick();
    addr_vld = 1'b0;
    chk("t2_en_b", {31'b0, bram_en}, 32'd0);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    chk("t2_drained", exp_q.size(), 32'd0);
    chk("t2_count", n_out - n0, 32'd2);

    // Backpressure: 8 credits, then a dropped request sets overflow
    n0 = n_out;
    m_tready = 1'b0;
    addr_vld = 1'b1;
    for (int i = 0; i < 8; i++) begin
      x_in = 12'(10 + i); y_in = 12'd1;
      tick();
    end
    x_in = 12'd100; y_in = 12'd100;
    #1;
    chk("t3_ready_low", {31'b0, mem_ready}, 32'd0);
    chk("t3_ovf_before", {31'b0, overflow_err}, 32'd0);
    tick();
    addr_vld = 1'b0;
    chk("t3_ovf_set", {31'b0, overflow_err}, 32'd1);
    repeat (5) tick();
    head = exp_q[0];
    chk("t3_valid_held", {31'b0, m_tvalid}, 32'd1);
    chk("t3_head", {20'b0, m_tdata}, {20'b0, head});
    chk("t3_credit", {28'b0, dut.credit}, 32'd8);
    repeat (3) tick();
    chk("t3_head_stable", {20'b0, m_tdata}, {20'b0, head});
    chk("t3_no_output", n_out - n0, 32'd0);
    chk("t3_queued", exp_q.size(), 32'd8);
    m_tready = 1'b1;
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) tick();
    chk("t3_drained", exp_q.size(), 32'd0);
    chk("t3_count", n_out - n0, 32'd8);
    chk("t3_valid_low", {31'b0, m_tvalid}, 32'd0);
    chk("t3_ready_back", {31'b0, mem_ready}, 32'd1);

    // Streaming at credit 7: simultaneous accept and handshake
    n0 = n_out;
    m_tready = 1'b0;
    addr_vld = 1'b1;
    for (int i = 0; i < 7; i++) begin
      x_in = 12'(200 + i); y_in = 12'd5;
      tick();
    end
    addr_vld = 1'b0;
    repeat (6) tick();
    chk("t5_credit7", {28'b0, dut.credit}, 32'd7);
    m_tready = 1'b1;
    addr_vld = 1'b1;
    for (int i = 0; i < 100; i++) begin
      x_in = 12'((i * 37) % 1200);
      y_in = 12'((i * 13) % 1000);
      tick();
      chk("t5_credit_hold", {28'b0, dut.credit}, 32'd7);
    end
    addr_vld = 1'b0;
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) tick();
    chk("t5_drained", exp_q.size(), 32'd0);
    chk("t5_count", n_out - n0, 32'd107);

    // Reset with 3 reads in flight and 2 pixels in the FIFO
    m_tready = 1'b0;
    addr_vld = 1'b1;
    for (int i = 0; i < 5; i++) begin
      x_in = 12'(i); y_in = 12'd3;
      tick();
    end
    addr_vld = 1'b0;
    chk("t6_ovf_sticky", {31'b0, overflow_err}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("t6_valid", {31'b0, m_tvalid}, 32'd0);
    chk("t6_ready", {31'b0, mem_ready}, 32'd1);
    chk("t6_ovf_clr", {31'b0, overflow_err}, 32'd0);
    m_tready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t6_no_stale", {31'b0, m_tvalid}, 32'd0);
    end
    x_in = 12'd7; y_in = 12'd0; addr_vld = 1'b1;
    tick();
    addr_vld = 1'b0;
    repeat (3) tick();
    chk("t6_valid_new", {31'b0, m_tvalid}, 32'd1);
    chk("t6_tdata", {20'b0, m_tdata}, 32'd7);
    chk("t6_tuser", {31'b0, m_tuser}, 32'd1);
    tick();
    chk("t6_drained", exp_q.size(), 32'd0);

    // 4x3 image: tlast every 4th pixel, tuser on pixels 1 and 13, no gaps
    sn_out = 0;
    started = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (c < 13) begin
        s_addr_vld = 1'b1;
        s_x = 12'(c % 4);
        s_y = 12'((c / 4) % 3);
      end else begin
        s_addr_vld = 1'b0;
      end
      #1;
      if (c < 13) chk("s_mem_ready", {31'b0, s_mem_ready}, 32'd1);
      if (s_tvalid && s_tready) begin
        chk("s_tdata", {20'b0, s_tdata}, 32'(sn_out % 12));
        chk("s_tlast", {31'b0, s_tlast}, {31'b0, ((sn_out + 1) % 4 == 0)});
        chk("s_tuser", {31'b0, s_tuser}, {31'b0, ((sn_out + 1) % 12 == 1)});
        sn_out++;
        started = 1'b1;
      end else if (started && sn_out < 13) begin
        chk("s_gap", {31'b0, s_tvalid}, 32'd1);
      end
      tick();
    end
    chk("s_count", sn_out, 32'd13);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
